// File: rtl/spi_pkg.sv
// Shared SPI types and helpers for the master/slave pair.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_slave_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Counter width able to hold the value w itself (the "word full" count)
  function automatic int unsigned spi_bit_cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer for the {sclk, cs_n, mosi} pins with edge pulses
// on the synchronized SCLK and CS_n.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_sync,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic cs_n_sync,
  output logic cs_n_fall_c,
  output logic cs_n_rise_c,
  output logic mosi_sync
);

  // Bundle order {sclk, cs_n, mosi}; CS_n resets deasserted so reset exit
  // with an idle bus produces no spurious select edge.
  localparam int unsigned BUNDLE_W = 3;
  localparam logic [BUNDLE_W-1:0] RESET_VAL = 3'b010;

  logic [BUNDLE_W-1:0] stages [SYNC_STAGES];
  logic [BUNDLE_W-1:0] prev;
  logic [BUNDLE_W-1:0] synced;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stages[i] <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      stages[0] <= {sclk, cs_n, mosi};
      for (int i = 1; i < int'(SYNC_STAGES); i++) stages[i] <= stages[i-1];
      prev <= stages[SYNC_STAGES-1];
    end
  end

  assign synced      = stages[SYNC_STAGES-1];
  assign sclk_sync   = synced[2];
  assign cs_n_sync   = synced[1];
  assign mosi_sync   = synced[0];
  assign sclk_rise_c =  synced[2] & ~prev[2];
  assign sclk_fall_c = ~synced[2] &  prev[2];
  assign cs_n_rise_c =  synced[1] & ~prev[1];
  assign cs_n_fall_c = ~synced[1] &  prev[1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_n/MOSI in the system clock domain and
// shifts full-duplex MSB-first words of SPI_DATA_WIDTH bits.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_clock_polarity,
  input  logic                      i_clock_phase,
  input  logic [SPI_DATA_WIDTH-1:0] i_data_in,
  output logic [SPI_DATA_WIDTH-1:0] o_data_out,
  output logic                      o_done,
  output logic                      o_busy,
  output logic                      o_abort,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_clock,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_spi_miso_oe
);

  localparam int unsigned W  = SPI_DATA_WIDTH;
  localparam int unsigned CW = spi_bit_cnt_width(W);

  spi_slave_state_t state, state_next;
  spi_mode_t        mode_q;
  logic [W-1:0]     rx_shift, tx_shift;
  logic [CW-1:0]    bit_cnt;

  logic sclk_sync, sclk_rise_c, sclk_fall_c;
  logic cs_n_sync, cs_n_fall_c, cs_n_rise_c, mosi_sync;
  logic edge_c, lead_c, trail_c, word_full_c, end_c;
  logic sample_c, shift_c, done_c, abort_c, active_c;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .sclk        (i_spi_clock),
    .cs_n        (i_spi_cs_n),
    .mosi        (i_spi_mosi),
    .sclk_sync   (sclk_sync),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c),
    .cs_n_sync   (cs_n_sync),
    .cs_n_fall_c (cs_n_fall_c),
    .cs_n_rise_c (cs_n_rise_c),
    .mosi_sync   (mosi_sync)
  );

  // Leading edge moves SCLK away from its idle level, trailing edge returns to it
  assign edge_c      = sclk_rise_c | sclk_fall_c;
  assign lead_c      = edge_c & (sclk_sync != mode_q.cpol);
  assign trail_c     = edge_c & (sclk_sync == mode_q.cpol);
  assign word_full_c = (bit_cnt == CW'(W));
  // Level term also catches a deselect that landed during LOAD
  assign end_c       = cs_n_sync | cs_n_rise_c | ~i_enable;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_n_fall_c && i_enable) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT: begin
        if (word_full_c)  state_next = (!cs_n_sync && i_enable) ? LOAD : IDLE;
        else if (end_c)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A completed word takes priority over a deselect seen in the same cycle
  always_comb begin
    sample_c = 1'b0;
    shift_c  = 1'b0;
    done_c   = 1'b0;
    abort_c  = 1'b0;
    active_c = (state_next == LOAD) || (state_next == SHIFT);
    if (state == SHIFT) begin
      if (word_full_c) begin
        done_c = 1'b1;
      end else if (end_c) begin
        abort_c = (bit_cnt != '0);
      end else begin
        sample_c = mode_q.cpha ? trail_c : lead_c;
        // CPHA=0 already shows the MSB from LOAD; the trailing edge left
        // over from the previous word must not advance the new one
        shift_c  = mode_q.cpha ? lead_c : (trail_c && bit_cnt != '0);
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mode_q        <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      bit_cnt       <= '0;
      o_data_out    <= '0;
      o_done        <= 1'b0;
      o_abort       <= 1'b0;
      o_busy        <= 1'b0;
      o_spi_miso_oe <= 1'b0;
      o_spi_miso    <= 1'b0;
    end else begin
      o_done        <= done_c;
      o_abort       <= abort_c;
      o_busy        <= active_c;
      o_spi_miso_oe <= active_c;
      if (state == IDLE) mode_q <= spi_mode_t'({i_clock_polarity, i_clock_phase});
      if (done_c) o_data_out <= rx_shift;
      if (state == LOAD) begin
        tx_shift <= i_data_in;
        bit_cnt  <= '0;
        if (!mode_q.cpha) o_spi_miso <= i_data_in[W-1];
      end
      if (sample_c) begin
        rx_shift <= {rx_shift[W-2:0], mosi_sync};
        bit_cnt  <= bit_cnt + CW'(1);
      end
      if (shift_c) begin
        o_spi_miso <= mode_q.cpha ? tx_shift[W-1] : tx_shift[W-2];
        tx_shift   <= {tx_shift[W-2:0], 1'b0};
      end
      if (!active_c) o_spi_miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural SPI master at SCLK = clk/10 with a
// received-word scoreboard.
module tb_spi_slave;

  localparam int unsigned W    = 32;
  localparam int unsigned SYNC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable, cpol, cpha;
  logic         cs_n, sclk, mosi;
  logic [W-1:0] data_a, data_b, data_in;
  logic [W-1:0] data_out;
  logic         done, busy, abort, miso, oe;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  done_count = 0;
  int unsigned  abort_count = 0;
  int unsigned  active_cycles = 0;
  int unsigned  base_done;

  logic [W-1:0] exp_rx[$];
  logic [W-1:0] got_rx[$];

  always #5 clk = ~clk;

  // Second transmit word becomes visible once a done arrives after base_done
  assign data_in = (done_count > base_done) ? data_b : data_a;

  spi_slave #(.SPI_DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_enable         (enable),
    .i_clock_polarity (cpol),
    .i_clock_phase    (cpha),
    .i_data_in        (data_in),
    .o_data_out       (data_out),
    .o_done           (done),
    .o_busy           (busy),
    .o_abort          (abort),
    .i_spi_cs_n       (cs_n),
    .i_spi_clock      (sclk),
    .i_spi_mosi       (mosi),
    .o_spi_miso       (miso),
    .o_spi_miso_oe    (oe)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_count++;
        got_rx.push_back(data_out);
      end
      if (abort) abort_count++;
      if (busy || oe || miso) active_cycles++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    check({tag, "_rx_cnt"}, 64'(got_rx.size()), 64'(exp_rx.size()));
    while (got_rx.size() > 0 && exp_rx.size() > 0)
      check({tag, "_rx"}, 64'(got_rx.pop_front()), 64'(exp_rx.pop_front()));
    got_rx.delete();
    exp_rx.delete();
  endtask

  // Master: shifts nbits of mosi_all MSB-first, captures MISO on sample edges,
  // and counts MISO changes inside the half period after each sample edge.
  task automatic spi_xfer(input logic pol, input logic pha, input logic [63:0] mosi_all,
                          input int nbits, input bit raise_cs,
                          output logic [63:0] miso_all, output int unstable);
    logic m;
    miso_all = '0;
    unstable = 0;
    m        = 1'b0;
    cpol = pol; cpha = pha; sclk = pol; cs_n = 1'b1; mosi = 1'b0;
    repeat (8) @(negedge clk);
    if (!pha) mosi = mosi_all[63];
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      sclk = ~pol;
      if (!pha) begin m = miso; miso_all[63-k] = m; end
      else mosi = mosi_all[63-k];
      repeat (4) @(negedge clk);
      if (!pha && (k % W) != W-1 && miso !== m) unstable++;
      @(negedge clk);
      sclk = pol;
      if (pha) begin m = miso; miso_all[63-k] = m; end
      else if (k < 63) mosi = mosi_all[62-k];
      repeat (4) @(negedge clk);
      if (pha && (k % W) != W-1 && miso !== m) unstable++;
      @(negedge clk);
    end
    if (raise_cs) begin
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  mw;
    int           unst;
    int unsigned  d0, a0, act0;
    rst = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0;
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    data_a = '0; data_b = '0; base_done = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst_data", 64'(data_out), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_abort", 64'(abort), 64'h0);
    check("rst_miso", 64'(miso), 64'h0);
    check("rst_oe", 64'(oe), 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // All four modes, single word
    data_a = 32'h1234_5678;
    for (int m = 0; m < 4; m++) begin
      d0 = done_count;
      exp_rx.push_back(32'hA5A5_0F0F);
      spi_xfer(m[1], m[0], {32'hA5A5_0F0F, 32'h0}, 32, 1'b1, mw, unst);
      check($sformatf("m%0d_miso", m), 64'(mw[63:32]), 64'h1234_5678);
      check($sformatf("m%0d_stable", m), 64'(unst), 64'h0);
      check($sformatf("m%0d_done", m), 64'(done_count - d0), 64'h1);
      drain($sformatf("m%0d", m));
    end

    // Back-to-back words with transmit data switched after the first done
    data_a = 32'hCAFE_F00D; data_b = 32'h1357_9BDF;
    base_done = done_count;
    d0 = done_count;
    exp_rx.push_back(32'hDEAD_BEEF);
    exp_rx.push_back(32'h0000_0001);
    spi_xfer(1'b0, 1'b0, {32'hDEAD_BEEF, 32'h0000_0001}, 64, 1'b1, mw, unst);
    check("b2b_miso0", 64'(mw[63:32]), 64'hCAFE_F00D);
    check("b2b_miso1", 64'(mw[31:0]), 64'h1357_9BDF);
    check("b2b_stable", 64'(unst), 64'h0);
    check("b2b_done", 64'(done_count - d0), 64'h2);
    drain("b2b");
    base_done = 32'hFFFF_FFFF;

    // Deselect after 10 bits
    d0 = done_count; a0 = abort_count;
    spi_xfer(1'b0, 1'b0, {32'h0F0F_3C3C, 32'h0}, 10, 1'b0, mw, unst);
    check("abt_busy_pre", 64'(busy), 64'h1);
    cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("abt_busy", 64'(busy), 64'h0);
    check("abt_oe", 64'(oe), 64'h0);
    repeat (4) @(negedge clk);
    check("abt_pulse", 64'(abort_count - a0), 64'h1);
    check("abt_done", 64'(done_count - d0), 64'h0);
    check("abt_data", 64'(data_out), 64'h0000_0001);
    drain("abt");

    // Reset in the middle of a word, then a clean transfer
    d0 = done_count; a0 = abort_count;
    spi_xfer(1'b0, 1'b0, {32'hFFFF_0000, 32'h0}, 16, 1'b0, mw, unst);
    rst = 1'b1;
    #1;
    check("mrst_busy", 64'(busy), 64'h0);
    check("mrst_oe", 64'(oe), 64'h0);
    check("mrst_data", 64'(data_out), 64'h0);
    check("mrst_miso", 64'(miso), 64'h0);
    cs_n = 1'b1; sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst_abort", 64'(abort_count - a0), 64'h0);
    data_a = 32'h0BAD_CAFE;
    exp_rx.push_back(32'h5555_AAAA);
    spi_xfer(1'b0, 1'b0, {32'h5555_AAAA, 32'h0}, 32, 1'b1, mw, unst);
    check("mrst_miso_w", 64'(mw[63:32]), 64'h0BAD_CAFE);
    check("mrst_done", 64'(done_count - d0), 64'h1);
    drain("mrst");

    // Disabled: bus must be ignored entirely
    enable = 1'b0;
    d0 = done_count; act0 = active_cycles;
    spi_xfer(1'b1, 1'b1, {32'h5A5A_5A5A, 32'h0}, 32, 1'b1, mw, unst);
    check("dis_active", 64'(active_cycles - act0), 64'h0);
    check("dis_done", 64'(done_count - d0), 64'h0);
    check("dis_miso_w", 64'(mw[63:32]), 64'h0);
    drain("dis");
    enable = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
